elementwise_mult_scheduler: RTL

- Round-robin arbiter and sequencer that shares one narrow elementwise-multiply datapath of LANES multipliers between M requesters.
- Each requester offers a full vector pair: N elements of N bits per operand.
- The block latches the granted pair and computes the unsigned 2N-bit products LANES elements per cycle over N/LANES cycles.
- It returns the N-element result vector tagged with the requester id. It sits between the vector producers and downstream consumers, replacing M fully parallel elementwise multipliers.

---
 rtl/elementwise_mult_scheduler.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/elementwise_mult_scheduler.sv
// Round-robin scheduler sharing LANES unsigned multipliers between M vector requesters.
// Optional perf counters (perf_jobs, perf_stall) are built when ELEMWISE_SCHED_PERF_EN is defined.
module elementwise_mult_scheduler #(
    parameter int N     = 8,
    parameter int M     = 2,
    parameter int LANES = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [M-1:0]                         req,
    input  logic [M*N*N-1:0]                     a_flat,
    input  logic [M*N*N-1:0]                     b_flat,
    output logic [M-1:0]                         gnt,
    output logic                                 busy,
    output logic                                 res_valid,
    input  logic                                 res_ready,
    output logic [((M > 1) ? $clog2(M) : 1)-1:0] res_id,
`ifdef ELEMWISE_SCHED_PERF_EN
    output logic [31:0]                          perf_jobs,
    output logic [31:0]                          perf_stall,
`endif
    output logic [2*N*N-1:0]                     res_flat
);

    localparam int IDW    = (M > 1) ? $clog2(M) : 1;
    localparam int CHUNKS = N / LANES;
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    generate
        if (N % LANES != 0) begin : g_lanes_check
            $error("elementwise_mult_scheduler: N must be a multiple of LANES");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, GRANT, COMPUTE, DONE} state_t;

    state_t           state;
    logic [IDW-1:0]   ptr;
    logic [CW-1:0]    chunk;
    logic [N*N-1:0]   op_a;
    logic [N*N-1:0]   op_b;

    logic [IDW-1:0]   win;
    logic [IDW-1:0]   win_hi;
    logic [IDW-1:0]   win_lo;
    logic             found_hi;
    logic             found_lo;
    int unsigned      base;
    logic [2*N-1:0]   prod [LANES];

    // Rotating priority: prefer the lowest set request above ptr, else wrap to the lowest overall.
    always_comb begin
        win_hi   = '0;
        win_lo   = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int unsigned i = 0; i < M; i++) begin
            if (req[i]) begin
                if (!found_lo) begin
                    found_lo = 1'b1;
                    win_lo   = IDW'(i);
                end
                if (!found_hi && i > 32'(ptr)) begin
                    found_hi = 1'b1;
                    win_hi   = IDW'(i);
                end
            end
        end
        win = found_hi ? win_hi : win_lo;
    end

    always_comb begin
        base = 32'(chunk) * LANES;
        for (int unsigned l = 0; l < LANES; l++) begin
            prod[l] = (2*N)'(op_a[(base + l)*N +: N]) * (2*N)'(op_b[(base + l)*N +: N]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= IDW'(M - 1);
            chunk     <= '0;
            op_a      <= '0;
            op_b      <= '0;
            gnt       <= '0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_flat  <= '0;
        end else begin
            gnt <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        state  <= GRANT;
                        gnt    <= M'(1) << win;
                        op_a   <= a_flat[32'(win)*N*N +: N*N];
                        op_b   <= b_flat[32'(win)*N*N +: N*N];
                        res_id <= win;
                        chunk  <= '0;
                        busy   <= 1'b1;
                    end
                end
                GRANT: begin
                    state <= COMPUTE;
                end
                COMPUTE: begin
                    for (int unsigned l = 0; l < LANES; l++) begin
                        res_flat[(base + l)*2*N +: 2*N] <= prod[l];
                    end
                    if (chunk == CW'(CHUNKS - 1)) begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                    end else begin
                        chunk <= chunk + 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        ptr       <= res_id;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ELEMWISE_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_jobs  <= '0;
            perf_stall <= '0;
        end else begin
            if (res_valid && res_ready) begin
                perf_jobs <= perf_jobs + 32'd1;
            end
            if (state == DONE && !res_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule
